// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the write-back path: register width, load
// funct3 encodings and the registered write-back record.
package rv32_pkg;

  localparam int REG_W = 5;
  localparam int XLEN  = 32;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } ld_funct3_e;

  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
    logic             err;
  } wb_result_t;

  function automatic logic ld_funct3_legal(input logic [2:0] f3);
    logic legal;
    case (ld_funct3_e'(f3))
      LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: legal = 1'b1;
      default:                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Byte/halfword lane select and sign/zero extension of a raw aligned load word.
// Illegal funct3 values produce zero data and raise illegal.
module load_extend
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data,
  output logic            illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    illegal  = !ld_funct3_legal(funct3);
    data     = '0;
    case (ld_funct3_e'(funct3))
      LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data = {24'd0, byte_sel};
      LD_LH:   data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  data = {16'd0, half_sel};
      // Word loads ignore the byte offset: the address is assumed aligned.
      LD_LW:   data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter between an unstallable-by-default ALU and a
// load response port, with load starvation protection and a pending-load scoreboard.
module wb_arbiter
  import rv32_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  input  logic [REG_W-1:0] alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [REG_W-1:0] ld_rd,
  input  logic [XLEN-1:0]  ld_word,
  input  logic [2:0]       ld_funct3,
  input  logic [1:0]       ld_addr_lo,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rd,
  input  logic [REG_W-1:0] rs1_num,
  input  logic [REG_W-1:0] rs2_num,
  input  logic [REG_W-1:0] rd_q,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rd_busy,
  output logic             alu_stall,
  output logic             ld_err,
  output logic             write,
  output logic [REG_W-1:0] rd_num,
  output logic [XLEN-1:0]  data
);

  localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

  logic [1:0]      wait_cnt_q, wait_cnt_d;
  logic [31:0]     pend_q, pend_d;
  wb_result_t      res_q, res_d;

  logic            starve;
  logic            alu_grant;
  logic            ld_accept;
  logic [XLEN-1:0] ld_ext;
  logic            ld_illegal;

  function automatic logic [1:0] sat_inc(input logic [1:0] v, input logic [1:0] lim);
    return (v >= lim) ? lim : v + 2'd1;
  endfunction

  function automatic logic busy_of(input logic [31:0] pend, input logic [REG_W-1:0] num);
    return (num != '0) && pend[num];
  endfunction

  load_extend u_load_extend (
    .word    (ld_word),
    .funct3  (ld_funct3),
    .addr_lo (ld_addr_lo),
    .data    (ld_ext),
    .illegal (ld_illegal)
  );

  // Arbitration: the ALU wins unless a load has waited STARVE_MAX cycles.
  always_comb begin
    starve    = rst_n && ld_valid && (wait_cnt_q == STARVE_LIM);
    alu_stall = starve;
    ld_ready  = rst_n && (!alu_valid || starve);
    ld_accept = ld_valid && ld_ready;
    alu_grant = rst_n && alu_valid && !starve;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!ld_valid || ld_accept) begin
      wait_cnt_d = 2'd0;
    end else begin
      wait_cnt_d = sat_inc(wait_cnt_q, STARVE_LIM);
    end
  end

  // rd_num/data hold their last value when nothing is granted.
  always_comb begin
    res_d      = res_q;
    res_d.vld  = 1'b0;
    res_d.err  = 1'b0;
    if (ld_accept) begin
      res_d.vld  = (ld_rd != '0);
      res_d.rd   = ld_rd;
      res_d.data = ld_ext;
      res_d.err  = ld_illegal;
    end else if (alu_grant) begin
      res_d.vld  = (alu_rd != '0);
      res_d.rd   = alu_rd;
      res_d.data = alu_data;
    end
  end

  // Clear before set so an issue and a retire on the same register keep it pending.
  always_comb begin
    pend_d = pend_q;
    if (ld_accept) begin
      pend_d[ld_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      pend_d[issue_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= 2'd0;
      pend_q     <= '0;
      res_q      <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      pend_q     <= pend_d;
      res_q      <= res_d;
    end
  end

  always_comb begin
    rs1_busy = busy_of(pend_q, rs1_num);
    rs2_busy = busy_of(pend_q, rs2_num);
    rd_busy  = busy_of(pend_q, rd_q);
    write    = res_q.vld;
    rd_num   = res_q.rd;
    data     = res_q.data;
    ld_err   = res_q.err;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized bench for wb_arbiter, checked against a behavioural
// model of the write-back rules kept in this file.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_word;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_num, rs2_num, rd_q;
  logic        rs1_busy, rs2_busy, rd_busy;
  logic        alu_stall;
  logic        ld_err;
  logic        write;
  logic [4:0]  rd_num;
  logic [31:0] data;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit pend_m[32];
  int wait_m = 0;

  wb_arbiter #(.STARVE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_word(ld_word),
    .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_num(rs1_num), .rs2_num(rs2_num), .rd_q(rd_q),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .alu_stall(alu_stall), .ld_err(ld_err),
    .write(write), .rd_num(rd_num), .data(data)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_m(input logic [2:0] f3);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  // Lane extraction by shifting and range arithmetic.
  function automatic logic [31:0] ext_m(input logic [31:0] w, input logic [2:0] f3,
                                        input logic [1:0] a);
    logic [31:0] sh;
    int v;
    case (f3)
      3'd0, 3'd4: begin
        sh = w >> (8 * int'(a));
        v  = int'(sh & 32'hFF);
        if (f3 == 3'd0 && v >= 128) v -= 256;
        return 32'(v);
      end
      3'd1, 3'd5: begin
        sh = w >> (16 * int'(a[1]));
        v  = int'(sh & 32'hFFFF);
        if (f3 == 3'd1 && v >= 32768) v -= 65536;
        return 32'(v);
      end
      3'd2:    return w;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic busy_m(input logic [4:0] n);
    return (n != 5'd0) && pend_m[n];
  endfunction

  task automatic idle();
    rst_n = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_word = '0; ld_funct3 = 3'd2; ld_addr_lo = '0;
    issue_valid = 1'b0; issue_rd = '0; rs1_num = '0; rs2_num = '0; rd_q = '0;
  endtask

  // One clock: check combinational outputs, predict, clock, check registered outputs.
  task automatic tick();
    logic        stall_e, ready_e, ld_acc, alu_acc, err_e, wr_e;
    logic [4:0]  rd_e;
    logic [31:0] d_e;
    #1;
    stall_e = rst_n && ld_valid && (wait_m == 3);
    ready_e = rst_n && (!alu_valid || stall_e);
    chk1("alu_stall", alu_stall, stall_e);
    chk1("ld_ready", ld_ready, ready_e);
    chk1("rs1_busy", rs1_busy, busy_m(rs1_num));
    chk1("rs2_busy", rs2_busy, busy_m(rs2_num));
    chk1("rd_busy", rd_busy, busy_m(rd_q));
    ld_acc  = ld_valid && ready_e;
    alu_acc = rst_n && alu_valid && !stall_e;
    rd_e = '0; d_e = '0; err_e = 1'b0;
    if (ld_acc) begin
      rd_e  = ld_rd;
      err_e = !legal_m(ld_funct3);
      d_e   = err_e ? 32'd0 : ext_m(ld_word, ld_funct3, ld_addr_lo);
    end else if (alu_acc) begin
      rd_e = alu_rd;
      d_e  = alu_data;
    end
    wr_e = (ld_acc || alu_acc) && (rd_e != 5'd0);
    @(posedge clk);
    #1;
    chk1("write", write, wr_e);
    chk1("ld_err", ld_err, err_e);
    if (wr_e) begin
      chk32("rd_num", {27'd0, rd_num}, {27'd0, rd_e});
      chk32("data", data, d_e);
    end
    if (!rst_n) begin
      chk32("rst_rd_num", {27'd0, rd_num}, 32'd0);
      chk32("rst_data", data, 32'd0);
      foreach (pend_m[i]) pend_m[i] = 1'b0;
      wait_m = 0;
    end else begin
      if (ld_acc) pend_m[ld_rd] = 1'b0;
      if (issue_valid && issue_rd != 5'd0) pend_m[issue_rd] = 1'b1;
      if (ld_valid && !ready_e) wait_m = (wait_m >= 3) ? 3 : wait_m + 1;
      else wait_m = 0;
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    // Reset state
    rst_n = 1'b0;
    tick();
    chk1("reset_write", write, 1'b0);
    chk1("reset_ld_err", ld_err, 1'b0);
    idle();
    tick();

    // ALU-only write-back
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    tick();
    chk1("alu_write", write, 1'b1);
    chk32("alu_rd_num", {27'd0, rd_num}, 32'd5);
    chk32("alu_data", data, 32'h0000_1234);
    idle();

    // Load extension
    ld_valid = 1'b1; ld_rd = 5'd9; ld_word = 32'h80FF_7F01; ld_funct3 = 3'b000; ld_addr_lo = 2'd3;
    tick();
    chk32("lb_data", data, 32'hFFFF_FF80);
    ld_funct3 = 3'b101; ld_addr_lo = 2'd2;
    tick();
    chk32("lhu_data", data, 32'h0000_80FF);
    idle();
    tick();

    // Starvation: load waits three cycles, is forced in the fourth
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = $urandom;
      ld_valid = 1'b1; ld_rd = 5'd12; ld_word = 32'hCAFE_F00D; ld_funct3 = 3'b010;
      #1;
      chk1("starve_ready", ld_ready, i == 3);
      chk1("starve_stall", alu_stall, i == 3);
      tick();
    end
    chk32("starve_ld_rd", {27'd0, rd_num}, 32'd12);
    chk32("starve_ld_data", data, 32'hCAFE_F00D);
    idle();
    tick();

    // Scoreboard set/clear/priority
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle(); rs1_num = 5'd7;
    #1;
    chk1("sb_set", rs1_busy, 1'b1);
    tick();
    ld_valid = 1'b1; ld_rd = 5'd7; rs1_num = 5'd7;
    tick();
    idle(); rs1_num = 5'd7;
    #1;
    chk1("sb_clear", rs1_busy, 1'b0);
    tick();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    ld_valid = 1'b1; ld_rd = 5'd7;
    tick();
    idle(); rs1_num = 5'd7;
    #1;
    chk1("sb_set_priority", rs1_busy, 1'b1);
    tick();

    // Illegal funct3 and rd=0 suppression
    ld_valid = 1'b1; ld_rd = 5'd3; ld_funct3 = 3'b011; ld_word = 32'hFFFF_FFFF;
    tick();
    chk1("illegal_write", write, 1'b1);
    chk32("illegal_data", data, 32'd0);
    chk1("illegal_err", ld_err, 1'b1);
    idle();
    tick();
    chk1("illegal_err_pulse", ld_err, 1'b0);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h5555_AAAA;
    tick();
    chk1("rd0_write", write, 1'b0);
    idle();

    // Reset mid-stream with a pending load and an accepted result
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h0000_0006;
      ld_valid = 1'b1; ld_rd = 5'd2;
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk1("rst_ready", ld_ready, 1'b0);
    chk1("rst_stall", alu_stall, 1'b0);
    tick();
    chk1("rst_write", write, 1'b0);
    idle(); rs1_num = 5'd7; rs2_num = 5'd7; rd_q = 5'd7;
    #1;
    chk1("rst_busy", rs1_busy | rs2_busy | rd_busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd6; alu_data = $urandom;
      ld_valid = 1'b1; ld_rd = 5'd2; ld_funct3 = 3'b010;
      #1;
      chk1("rst_wait_cleared", ld_ready, i == 3);
      tick();
    end
    idle();
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst_n       = ($urandom_range(0, 59) != 0);
      alu_valid   = 1'($urandom_range(0, 1));
      alu_rd      = 5'($urandom);
      alu_data    = $urandom;
      ld_valid    = ($urandom_range(0, 2) != 0);
      ld_rd       = 5'($urandom);
      ld_word     = $urandom;
      ld_funct3   = 3'($urandom);
      ld_addr_lo  = 2'($urandom);
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom);
      rs1_num     = 5'($urandom);
      rs2_num     = 5'($urandom);
      rd_q        = 5'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3, meaning the number of load wait cycles before ALU back-pressure is applied.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port alu_valid  in  1  ALU result present this cycle; it cannot be stalled except via alu_stall.
REQ-005 SHALL have port alu_rd  in  5  ALU destination register.
REQ-006 SHALL have port alu_data  in  32  ALU result.
REQ-007 SHALL have port ld_valid  in  1  load response valid.
REQ-008 SHALL have port ld_ready  out  1  load response accepted when ld_valid && ld_ready.
REQ-009 SHALL have port ld_rd  in  5  load destination register.
REQ-010 SHALL have port ld_word  in  32  raw aligned memory word.
REQ-011 SHALL have port ld_funct3  in  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
REQ-012 SHALL have port ld_addr_lo  in  2  byte offset of the load address.
REQ-013 SHALL have port issue_valid  in  1  load issued to memory this cycle.
REQ-014 SHALL have port issue_rd  in  5  destination register of the issued load.
REQ-015 SHALL have port rs1_num, rs2_num, rd_q  in  5 each  registers queried by decode.
REQ-016 SHALL have port rs1_busy, rs2_busy, rd_busy  out  1 each  queried register has a load outstanding.
REQ-017 SHALL have port alu_stall  out  1  upstream must hold ALU results this cycle.
REQ-018 SHALL have port ld_err  out  1  one-cycle pulse on an accepted load with an illegal funct3.
REQ-019 SHALL have port write, rd_num, data  out  1/5/32  register-file write port, registered.

Function
REQ-020 SHALL register the winning result so that a result accepted in cycle N appears on write/rd_num/data in cycle N+1 (latency 1, one write per cycle).
REQ-021 SHALL grant the ALU when alu_valid=1 and alu_stall=0; ld_ready SHALL then be 0.
REQ-022 SHALL set ld_ready=1 whenever alu_valid=0 or alu_stall=1.
REQ-023 SHALL keep a 2-bit wait counter: +1 per cycle with ld_valid && !ld_ready, cleared on load accept or when ld_valid=0, saturating at STARVE_MAX.
REQ-024 SHALL assert alu_stall combinationally while wait_cnt==STARVE_MAX && ld_valid, grant the load in that cycle, and ignore alu_valid in that cycle.
REQ-025 SHALL drive write=0 in cycle N+1 for any granted result with rd=0; a load with rd=0 SHALL still be accepted.
REQ-026 SHALL extend load data as follows: lb/lbu select byte ld_addr_lo and sign/zero-extend it; lh/lhu select halfword ld_addr_lo[1] and sign/zero-extend it; lw passes ld_word unchanged, ignoring ld_addr_lo.
REQ-027 SHALL, for an illegal funct3, write data=0 to rd (rd!=0) and pulse ld_err in cycle N+1.
REQ-028 SHALL hold a scoreboard pend[31:1]: set bit issue_rd on issue_valid (issue_rd!=0), clear bit ld_rd on load accept.
REQ-029 SHALL give set priority when set and clear hit the same register in the same cycle (bit stays 1).
REQ-030 SHALL leave the bit at 1 and not count a re-issue to an already-pending register; upstream must prevent this using rd_busy.
REQ-031 SHALL compute xx_busy combinationally as pend[num] for num!=0 and as 0 for num=0; a clear SHALL be visible in the cycle after accept.
REQ-032 SHALL NOT forward data; the consumer waits for busy=0 and then reads the register file.

Reset
REQ-033 SHALL, on rst_n=0 at posedge, clear write, rd_num, data, ld_err, pend and wait_cnt to 0.
REQ-034 SHALL force ld_ready=0 and alu_stall=0 while rst_n=0.
REQ-035 SHALL discard any result accepted in the cycle of reset; an in-flight load's pend bit SHALL be lost, and the memory side is flushed by the same reset.

Structure
REQ-036 SHALL take load funct3 encodings (enum) and REG_W=5 from shared package rv32_pkg.
REQ-037 SHALL place byte/halfword select and extension in a combinational sub-module load_extend.

Verification
REQ-038 SHALL cover: ALU-only case: alu_valid, rd=5, data=0x1234 -> next cycle write=1, rd_num=5, data=0x00001234.
REQ-039 SHALL cover: lb with ld_word=0x80FF7F01, addr_lo=3 -> data=0xFFFFFF80; lhu with addr_lo=2 -> data=0x000080FF.
REQ-040 SHALL cover: alu_valid held 1 and ld_valid held 1 -> ld_ready=0 for 3 cycles, alu_stall=1 in the 4th, load written in the 5th.
REQ-041 SHALL cover: issue rd=7 -> rs1_busy=1 for rs1_num=7; load rd=7 accepted -> busy=0 in the next cycle; simultaneous issue rd=7 and accept rd=7 -> busy stays 1.
REQ-042 SHALL cover: ld_funct3=011, rd=3 -> write=1, data=0, ld_err=1 for exactly one cycle; ALU rd=0 -> write=0.
REQ-043 SHALL cover: rst_n=0 mid-stream with pend=0x80 and a result accepted -> next cycle write=0, all busy=0, wait_cnt=0.
